// File: rtl/ula_pkg.sv
// Shared definitions for the arbitrated 8-bit ALU: opcodes, FSM states and
// the divide-by-zero result value.
package ula_pkg;

  localparam logic [1:0] OP_SOMA = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_div0(input logic [1:0] op, input logic [7:0] b);
    return (op == OP_DIV) && (b == 8'd0);
  endfunction

endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin picker: selects the first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ.
module rr_arbitro #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down to rr_ptr so the nearest hit wins last
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula.sv
// Combinational 8-bit ALU: add, subtract, multiply and unsigned divide,
// every result truncated to 8 bits.
module ula
  import ula_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_SOMA: r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      // Zero divisor yields 0 here; the caller substitutes its own marker value
      default: r = (b == 8'd0) ? 8'd0 : a / b;
    endcase
  end

endmodule

// File: rtl/ula_arbitro.sv
// Shares one ula among NUM_REQ valid/ready requesters with round-robin
// arbitration; results are returned registered, tagged with the owner's ID.
module ula_arbitro
  import ula_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*2-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_div0,
  output logic                 busy,
  output logic [15:0]          op_count
);

  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];
  logic [1:0] op_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[8*gi +: 8];
      assign b_arr[gi]  = req_b[8*gi +: 8];
      assign op_arr[gi] = req_op[2*gi +: 2];
    end
  endgenerate

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      res_data_q, res_data_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic            res_div0_q, res_div0_d;
  logic            res_valid_q, res_valid_d;
  logic [15:0]     op_count_q, op_count_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [7:0]         ula_r;

  rr_arbitro #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbitro (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  ula u_ula (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .r  (ula_r)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_div0_d  = res_div0_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          a_d     = a_arr[grant_id];
          b_d     = b_arr[grant_id];
          op_d    = op_arr[grant_id];
          id_d    = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_div0_d  = is_div0(op_q, b_q);
        res_data_d  = is_div0(op_q, b_q) ? DIV0_RESULT : ula_r;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
          // Next search starts just past the requester that was served
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_div0_q  <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_div0_q  <= res_div0_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_div0  = res_div0_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule
